// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the APB command master.
// Latency: none (declarations only).
// Backpressure: not applicable.
package apb_cmd_master_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    // Low address bits that must be zero for a word-aligned transfer
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        CAPTURE,
        RESP
    } state_t;

    function automatic logic is_misaligned(input logic [APB_AW-1:0] addr);
        return (addr[1:0] & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB signal bundle between the requester and its neighbours.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready; pready only when APB_PREADY_EN is defined.
interface apb_cmd_master_if;
    import apb_cmd_master_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [APB_AW-1:0] cmd_addr;
    logic [APB_DW-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [APB_DW-1:0] rsp_rdata;
    logic              rsp_err;

    logic [APB_AW-1:0] paddr;
    logic [APB_DW-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_DW-1:0] prdata;
`ifdef APB_PREADY_EN
    logic              pready;
`endif

    modport master (
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwdata, psel, penable, pwrite,
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata
`ifdef APB_PREADY_EN
        , input pready
`endif
    );

    modport slave (
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwdata, psel, penable, pwrite,
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata
`ifdef APB_PREADY_EN
        , output pready
`endif
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// 8-bit saturating cycle counter with clear, enable and terminal-count flag.
// Latency: tc is combinational from the current count and enable.
// Backpressure: none; counts whenever enabled.
module apb_timeout_cnt #(
    parameter int TC = 15
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_V = 8'(TC);

    logic [7:0] cnt_q;

    // Count enabled cycles, restarting from zero whenever cleared
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= 8'd0;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (en && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tc = en && (cnt_q == TC_V);

endmodule

// File: rtl/apb_cmd_master.sv
// One-at-a-time APB requester: command in, one APB transfer, one response out (APB_PREADY_EN adds wait states/timeout).
// Latency: accept to rsp_valid = 3 cycles write, 3+RD_CAPTURE read, 1 misaligned.
// Backpressure: cmd_ready only in IDLE; RESP holds all outputs until rsp_ready.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int RD_CAPTURE = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_cmd_master_if.master bus
);

    if ((RD_CAPTURE < 0) || (RD_CAPTURE > 3)) begin : g_bad_rd_capture
        $error("RD_CAPTURE out of range 0..3");
    end
    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("TIMEOUT out of range 2..255");
    end

    // CAPTURE counts down from this value to zero
    localparam logic [1:0] CAP_LAST = (RD_CAPTURE > 0) ? 2'(RD_CAPTURE - 1) : 2'd0;

    state_t            state_q, state_d;
    logic [1:0]        cap_cnt_q, cap_cnt_d;
    logic [APB_AW-1:0] paddr_q;
    logic [APB_DW-1:0] pwdata_q;
    logic              pwrite_q;
    logic [APB_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              psel_q, penable_q, cmd_ready_q, rsp_valid_q;
    logic              accept;
    logic              access_done;
    logic              access_tmo;

    assign accept = bus.cmd_valid && cmd_ready_q;

`ifdef APB_PREADY_EN
    logic tmo_tc;

    apb_timeout_cnt #(
        .TC (TIMEOUT - 1)
    ) u_timeout_cnt (
        .pclk    (pclk),
        .presetn (presetn),
        .clr     (state_q != ACCESS),
        .en      (state_q == ACCESS),
        .tc      (tmo_tc)
    );

    assign access_done = bus.pready;
    assign access_tmo  = !bus.pready && tmo_tc;
`else
    assign access_done = 1'b1;
    assign access_tmo  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, capture countdown and response contents
    always_comb begin
        state_d   = state_q;
        cap_cnt_d = cap_cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = '0;
                    if (is_misaligned(bus.cmd_addr)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (access_tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else if (access_done) begin
                    if (pwrite_q) begin
                        state_d = RESP;
                    end else if (RD_CAPTURE == 0) begin
                        rdata_d = bus.prdata;
                        state_d = RESP;
                    end else begin
                        cap_cnt_d = CAP_LAST;
                        state_d   = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (cap_cnt_q == 2'd0) begin
                    rdata_d = bus.prdata;
                    state_d = RESP;
                end else begin
                    cap_cnt_d = cap_cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; control outputs decode the next state so they are flop-driven
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cap_cnt_q   <= 2'd0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            cap_cnt_q   <= cap_cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            if (accept) begin
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
                pwrite_q <= bus.cmd_write;
            end
            psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q   <= (state_d == ACCESS);
            cmd_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;

endmodule
